// File: rtl/stream_demux_1x4_if.sv
// Handshake bundle for stream_demux_1x4: one tagged input stream
// and four independent output channels, channel k at out_data[k*n +: n].
interface stream_demux_1x4_if #(
   parameter int n = 4
);
   logic [n-1:0]   in_data;
   logic [1:0]     in_sel;
   logic           in_valid;
   logic           in_ready;
   logic [4*n-1:0] out_data;
   logic [3:0]     out_valid;
   logic [3:0]     out_ready;

   modport master (
      output in_data,
      output in_sel,
      output in_valid,
      output out_ready,
      input  in_ready,
      input  out_data,
      input  out_valid
   );

   modport slave (
      input  in_data,
      input  in_sel,
      input  in_valid,
      input  out_ready,
      output in_ready,
      output out_data,
      output out_valid
   );
endinterface

// File: rtl/stream_demux_1x4.sv
// Registered 1-to-4 stream demultiplexer with a one-entry buffer per channel.
// Optional STREAM_DEMUX_STATS_EN adds stat_cnt: four wrapping 8-bit drain counters.
module stream_demux_1x4 #(
   parameter int n = 4
) (
   input  logic                clk,
   input  logic                rst,
   stream_demux_1x4_if.slave   bus
`ifdef STREAM_DEMUX_STATS_EN
   ,
   output logic [31:0]         stat_cnt
`endif
);

   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } state_t;

   state_t         state_q [4];
   state_t         state_d [4];
   logic [n-1:0]   data_q  [4];
   logic [3:0]     full;
   logic [3:0]     load;
   logic [3:0]     drain;
   logic           ready;
   logic [4*n-1:0] out_data_c;

   // Decode per-channel full, load and drain strobes
   always_comb begin
      full  = '0;
      load  = '0;
      drain = '0;
      for (int k = 0; k < 4; k++) begin
         full[k]  = (state_q[k] == FULL);
         drain[k] = full[k] & bus.out_ready[k];
         load[k]  = bus.in_valid & ready & (bus.in_sel == 2'(k));
      end
   end

   // Only the addressed channel can stall the producer
   assign ready = ~full[bus.in_sel] | bus.out_ready[bus.in_sel];

   // Per-channel next state: a drain with a same-cycle load stays FULL
   always_comb begin
      for (int k = 0; k < 4; k++) begin
         state_d[k] = state_q[k];
         unique case (state_q[k])
            EMPTY: if (load[k]) state_d[k] = FULL;
            FULL:  if (drain[k] && !load[k]) state_d[k] = EMPTY;
            default: state_d[k] = EMPTY;
         endcase
      end
   end

   // Channel state registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k < 4; k++) state_q[k] <= EMPTY;
      end else begin
         for (int k = 0; k < 4; k++) state_q[k] <= state_d[k];
      end
   end

   // Holding registers change only when their channel is loaded
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k < 4; k++) data_q[k] <= '0;
      end else begin
         for (int k = 0; k < 4; k++)
            if (load[k]) data_q[k] <= bus.in_data;
      end
   end

   // Pack the channel registers onto the output bus
   always_comb begin
      out_data_c = '0;
      for (int k = 0; k < 4; k++) out_data_c[k*n +: n] = data_q[k];
   end

   assign bus.in_ready  = ready;
   assign bus.out_valid = full;
   assign bus.out_data  = out_data_c;

`ifdef STREAM_DEMUX_STATS_EN
   logic [7:0] cnt_q [4];

   // Count completed drains per channel, wrapping at 255
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k < 4; k++) cnt_q[k] <= '0;
      end else begin
         for (int k = 0; k < 4; k++)
            if (drain[k]) cnt_q[k] <= cnt_q[k] + 8'd1;
      end
   end

   assign stat_cnt = {cnt_q[3], cnt_q[2], cnt_q[1], cnt_q[0]};
`endif

endmodule

// File: tb/tb_stream_demux_1x4.sv
// Scoreboard bench for stream_demux_1x4 (n = 4).
// Accepted words queue per channel; a monitor pops on every drain.
module tb_stream_demux_1x4;

   logic clk;
   logic rst;
   int   n_checks;
   int   n_fail;

   logic [3:0] q [4][$];

   stream_demux_1x4_if #(.n(4)) bus ();

`ifdef STREAM_DEMUX_STATS_EN
   logic [31:0] stat_cnt;
`endif

   stream_demux_1x4 #(.n(4)) dut (
      .clk      (clk),
      .rst      (rst),
      .bus      (bus)
`ifdef STREAM_DEMUX_STATS_EN
      ,
      .stat_cnt (stat_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name,
                        input logic [31:0] act,
                        input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Drive a word for one cycle; queue it if it should be accepted
   task automatic send(input logic [3:0] d,
                       input logic [1:0] s,
                       input logic exp_rdy);
      bus.in_data  = d;
      bus.in_sel   = s;
      bus.in_valid = 1'b1;
      @(negedge clk);
      check("in_ready", {31'd0, bus.in_ready}, {31'd0, exp_rdy});
      if (exp_rdy) q[s].push_back(d);
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Monitor: every valid&ready seen before an edge is a drain at that edge
   always @(negedge clk) begin
      if (!rst) begin
         for (int k = 0; k < 4; k++) begin
            if (bus.out_valid[k] && bus.out_ready[k]) begin
               if (q[k].size() == 0) begin
                  check($sformatf("unexpected_ch%0d", k), 32'd1, 32'd0);
               end else begin
                  check($sformatf("drain_ch%0d", k),
                        {28'd0, bus.out_data[k*4 +: 4]},
                        {28'd0, q[k].pop_front()});
               end
            end
         end
      end
   end

   initial begin
      n_checks      = 0;
      n_fail        = 0;
      rst           = 1'b1;
      bus.in_data   = '0;
      bus.in_sel    = '0;
      bus.in_valid  = 1'b0;
      bus.out_ready = '0;

      #2;
      check("rst_out_valid", {28'd0, bus.out_valid}, 32'd0);
      check("rst_out_data", {16'd0, bus.out_data}, 32'd0);
      check("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
      step();
      step();
      rst = 1'b0;

      // Single route to ch1 and hold under backpressure
      send(4'hA, 2'b01, 1'b1);
      for (int i = 0; i < 5; i++) begin
         check("hold_valid", {28'd0, bus.out_valid}, 32'h2);
         check("hold_slice1", {28'd0, bus.out_data[7:4]}, 32'hA);
         step();
      end

      // ch1 stalls its own input only
      send(4'hB, 2'b01, 1'b0);
      send(4'hC, 2'b11, 1'b1);
      check("bp_slice1", {28'd0, bus.out_data[7:4]}, 32'hA);
      check("bp_valid", {28'd0, bus.out_valid}, 32'hA);
      bus.out_ready = 4'b1111;
      step();
      bus.out_ready = 4'b0000;
      check("bp_drained", {28'd0, bus.out_valid}, 32'd0);

      // Streaming to ch0 with the consumer always ready
      bus.out_ready = 4'b1111;
      for (int i = 1; i <= 4; i++) begin
         send(4'(i), 2'b00, 1'b1);
         check("stream_valid0", {31'd0, bus.out_valid[0]}, 32'd1);
      end
      step();
      check("stream_done", {28'd0, bus.out_valid}, 32'd0);

      // Fan-out to all four channels, then drain together
      bus.out_ready = 4'b0000;
      send(4'h5, 2'b00, 1'b1);
      send(4'h6, 2'b01, 1'b1);
      send(4'h7, 2'b10, 1'b1);
      send(4'h8, 2'b11, 1'b1);
      check("fan_valid", {28'd0, bus.out_valid}, 32'hF);
      check("fan_data", {16'd0, bus.out_data}, 32'h8765);
      bus.out_ready = 4'b1111;
      step();
      bus.out_ready = 4'b0000;
      check("fan_clear", {28'd0, bus.out_valid}, 32'd0);

      // Asynchronous reset while ch2 is full
      send(4'h9, 2'b10, 1'b1);
      check("pre_rst_valid", {28'd0, bus.out_valid}, 32'h4);
      #2;
      rst = 1'b1;
      #1;
      check("mid_rst_valid", {28'd0, bus.out_valid}, 32'd0);
      check("mid_rst_data", {16'd0, bus.out_data}, 32'd0);
      check("mid_rst_ready", {31'd0, bus.in_ready}, 32'd1);
      q[2].delete();
      step();
      rst = 1'b0;

`ifdef STREAM_DEMUX_STATS_EN
      // 300 drains on ch2 wrap its counter to 44
      bus.out_ready = 4'b0100;
      for (int i = 0; i < 300; i++) send(4'(i), 2'b10, 1'b1);
      step();
      bus.out_ready = 4'b0000;
      check("stat_cnt", stat_cnt, 32'h002C_0000);
`endif

      step();
      for (int k = 0; k < 4; k++)
         check($sformatf("q%0d_empty", k), q[k].size(), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule
